// File: rtl/spi_result_tx.sv
// SPI target-side transmitter: returns the CPU output register to the SPI host.
// A one-entry hold buffer is filled through a ready/valid port. The word is shifted
// out MSB first in SPI mode 0, with sclk and cs_n synchronised into the clk domain.
module spi_result_tx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  sclk,
  input  logic                  cs_n,
  output logic                  miso,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  underrun
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  // synchroniser chains plus one edge-detect flop per pin
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic                   sclk_d_r;
  logic                   cs_d_r;
  logic                   sclk_rise_s;
  logic                   sclk_fall_s;
  logic                   cs_fall_s;
  logic                   cs_rise_s;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [DATA_WIDTH-1:0]  hold_r;
  logic [DATA_WIDTH-1:0]  hold_nxt_s;
  logic                   hold_full_r;
  logic                   hold_full_nxt_s;
  logic [DATA_WIDTH-1:0]  shift_r;
  logic [DATA_WIDTH-1:0]  shift_nxt_s;
  logic [CW-1:0]          bit_cnt_r;
  logic [CW-1:0]          bit_cnt_nxt_s;
  logic                   underrun_r;
  logic                   underrun_nxt_s;
  logic                   miso_r;
  logic                   miso_nxt_s;
  logic                   busy_r;
  logic                   busy_nxt_s;
  logic                   done_r;
  logic                   done_nxt_s;
  logic                   aborted_r;
  logic                   aborted_nxt_s;
  logic                   accept_s;

  // move the host pins into the clk domain and remember the previous synced level
  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_sync_r <= '0;
      cs_sync_r   <= '0;
      sclk_d_r    <= 1'b0;
      cs_d_r      <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
      sclk_d_r    <= sclk_sync_r[SYNC_STAGES-1];
      cs_d_r      <= cs_sync_r[SYNC_STAGES-1];
    end
  end

  assign sclk_rise_s =  sclk_sync_r[SYNC_STAGES-1] & ~sclk_d_r;
  assign sclk_fall_s = ~sclk_sync_r[SYNC_STAGES-1] &  sclk_d_r;
  assign cs_rise_s   =  cs_sync_r[SYNC_STAGES-1]   & ~cs_d_r;
  assign cs_fall_s   = ~cs_sync_r[SYNC_STAGES-1]   &  cs_d_r;

  assign accept_s    = data_valid & ~hold_full_r;

  // next-state logic for the load port, transfer FSM and registered outputs
  always_comb begin
    state_nxt_s     = state_r;
    hold_nxt_s      = hold_r;
    hold_full_nxt_s = hold_full_r;
    shift_nxt_s     = shift_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    underrun_nxt_s  = underrun_r;
    done_nxt_s      = 1'b0;
    aborted_nxt_s   = 1'b0;

    // a word offered while the buffer is full is dropped, never overwrites
    if (accept_s) begin
      hold_nxt_s      = data_in;
      hold_full_nxt_s = 1'b1;
    end else begin
      hold_nxt_s      = hold_r;
    end

    case (state_r)
      IDLE: begin
        bit_cnt_nxt_s = '0;
        if (cs_fall_s) begin
          state_nxt_s = SHIFT;
          // accept_s is low whenever hold_full_r is set, so clearing here is safe
          if (hold_full_r) begin
            shift_nxt_s     = hold_r;
            hold_full_nxt_s = 1'b0;
          end else begin
            shift_nxt_s    = '0;
            underrun_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (cs_rise_s) begin
          aborted_nxt_s = 1'b1;
          bit_cnt_nxt_s = '0;
          state_nxt_s   = IDLE;
        end else if (sclk_rise_s) begin
          if (bit_cnt_r != CNT_FULL) begin
            bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r;
          end
          if (bit_cnt_r + CNT_ONE == CNT_FULL) begin
            done_nxt_s  = 1'b1;
            state_nxt_s = WAIT_CS;
          end else begin
            state_nxt_s = SHIFT;
          end
        end else if (sclk_fall_s) begin
          shift_nxt_s = {shift_r[DATA_WIDTH-2:0], 1'b0};
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      WAIT_CS: begin
        if (cs_rise_s) begin
          bit_cnt_nxt_s = '0;
          state_nxt_s   = IDLE;
        end else begin
          state_nxt_s = WAIT_CS;
        end
      end
      default: begin
        bit_cnt_nxt_s = '0;
        state_nxt_s   = IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s != IDLE);
    if (state_nxt_s == SHIFT) begin
      miso_nxt_s = shift_nxt_s[DATA_WIDTH-1];
    end else begin
      miso_nxt_s = 1'b0;
    end
  end

  // state, datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      hold_r      <= '0;
      hold_full_r <= 1'b0;
      shift_r     <= '0;
      bit_cnt_r   <= '0;
      underrun_r  <= 1'b0;
      miso_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      aborted_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      hold_r      <= hold_nxt_s;
      hold_full_r <= hold_full_nxt_s;
      shift_r     <= shift_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      underrun_r  <= underrun_nxt_s;
      miso_r      <= miso_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      aborted_r   <= aborted_nxt_s;
    end
  end

  assign data_ready = ~hold_full_r;
  assign miso       = miso_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign aborted    = aborted_r;
  assign underrun   = underrun_r;

endmodule

// File: tb/tb_spi_result_tx.sv
// Self-checking bench for spi_result_tx: directed vector table, hand-written
// corner sequences and a randomized run against a word-level reference model.
module tb_spi_result_tx;

  localparam int W  = 8;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         data_valid = 1'b0;
  logic         data_ready;
  logic         sclk = 1'b0;
  logic         cs_n = 1'b1;
  logic         miso;
  logic         busy;
  logic         done;
  logic         aborted;
  logic         underrun;

  int total = 0;
  int bad   = 0;
  int done_cnt  = 0;
  int abort_cnt = 0;

  spi_result_tx #(.DATA_WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .miso       (miso),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  // count pulses away from the active edge
  always @(negedge clk) begin
    done_cnt  <= done_cnt + (done ? 1 : 0);
    abort_cnt <= abort_cnt + (aborted ? 1 : 0);
  end

  typedef struct {
    bit         rst_before;
    bit         load;
    logic [7:0] word;
    int         nbits;
    logic [7:0] exp_rd;
    int         exp_done;
    int         exp_abort;
    bit         exp_underrun;
  } vec_t;

  vec_t tbl[6];

  // reference model state: one-entry buffer and sticky underrun
  bit         m_full;
  logic [7:0] m_hold;
  bit         m_under;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_full  = 1'b0;
    m_hold  = 8'h00;
    m_under = 1'b0;
  endtask

  task automatic model_load(input logic [7:0] w);
    if (!m_full) begin
      m_hold = w;
      m_full = 1'b1;
    end
  endtask

  // returns the bits the host should read for an n-bit transfer
  task automatic model_xfer(input int n, output logic [7:0] exp);
    logic [7:0] src;
    if (m_full) begin
      src    = m_hold;
      m_full = 1'b0;
    end else begin
      src     = 8'h00;
      m_under = 1'b1;
    end
    exp = src >> (8 - n);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cs_n = 1'b1;
    sclk = 1'b0;
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (SS + 3) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] w);
    data_in = w;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    repeat (SS + 6) @(negedge clk);
  endtask

  // host samples miso just before each rising sclk (mode 0)
  task automatic bits(input int n, output logic [7:0] rd);
    rd = 8'h00;
    for (int i = 0; i < n; i++) begin
      rd = {rd[6:0], miso};
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic cs_end(output logic busy_mid);
    busy_mid = busy;
    cs_n = 1'b1;
    repeat (SS + 6) @(negedge clk);
  endtask

  task automatic transfer(input int n, output logic [7:0] rd, output logic bm, output logic be);
    cs_start();
    bits(n, rd);
    cs_end(bm);
    be = busy;
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] exp;
    logic       bm;
    logic       be;
    int         d0;
    int         a0;
    int         n;
    logic [7:0] w;

    tbl[0] = '{1'b0, 1'b1, 8'hA5, 8, 8'hA5, 1, 0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 8, 8'h00, 1, 0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 8'h3C, 8, 8'h3C, 1, 0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 8'hFF, 3, 8'h07, 0, 1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 8, 8'h00, 1, 0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 8'h81, 8, 8'h81, 1, 0, 1'b1};

    // reset values while reset is held
    repeat (3) @(negedge clk);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_aborted", {31'd0, aborted}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_ready", {31'd0, data_ready}, 32'd1);
    reset = 1'b1;
    repeat (SS + 3) @(negedge clk);

    // directed vector table
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rst_before) do_reset();
      if (tbl[i].load) load(tbl[i].word);
      d0 = done_cnt;
      a0 = abort_cnt;
      transfer(tbl[i].nbits, rd, bm, be);
      check($sformatf("tbl%0d_rd", i), {24'd0, rd}, {24'd0, tbl[i].exp_rd});
      check($sformatf("tbl%0d_done", i), done_cnt - d0, tbl[i].exp_done);
      check($sformatf("tbl%0d_abort", i), abort_cnt - a0, tbl[i].exp_abort);
      check($sformatf("tbl%0d_underrun", i), {31'd0, underrun}, {31'd0, tbl[i].exp_underrun});
      check($sformatf("tbl%0d_ready", i), {31'd0, data_ready}, 32'd1);
      check($sformatf("tbl%0d_busy_mid", i), {31'd0, bm}, 32'd1);
      check($sformatf("tbl%0d_busy_end", i), {31'd0, be}, 32'd0);
    end

    // load during WAIT_CS stays held for the next transfer
    do_reset();
    load(8'h3C);
    check("t2_ready_after_accept", {31'd0, data_ready}, 32'd0);
    cs_start();
    bits(8, rd);
    check("t2_first_rd", {24'd0, rd}, 32'h3C);
    load(8'hC3);
    check("t2_ready_in_wait", {31'd0, data_ready}, 32'd0);
    cs_end(bm);
    check("t2_ready_before_next", {31'd0, data_ready}, 32'd0);
    transfer(8, rd, bm, be);
    check("t2_second_rd", {24'd0, rd}, 32'hC3);
    check("t2_ready_end", {31'd0, data_ready}, 32'd1);
    check("t2_underrun", {31'd0, underrun}, 32'd0);

    // load in the same cycle as the synced cs_n fall, buffer empty
    cs_n = 1'b0;
    repeat (SS) @(negedge clk);
    data_in = 8'h96;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check("t5_word_held", {31'd0, data_ready}, 32'd0);
    repeat (6) @(negedge clk);
    bits(8, rd);
    cs_end(bm);
    check("t5_first_rd", {24'd0, rd}, 32'h00);
    check("t5_underrun", {31'd0, underrun}, 32'd1);
    transfer(8, rd, bm, be);
    check("t5_second_rd", {24'd0, rd}, 32'h96);
    check("t5_ready_end", {31'd0, data_ready}, 32'd1);

    // reset in the middle of bit 4
    do_reset();
    load(8'hF0);
    cs_start();
    bits(3, rd);
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_miso_before", {31'd0, miso}, 32'd1);
    d0 = done_cnt;
    a0 = abort_cnt;
    reset = 1'b0;
    @(negedge clk);
    check("t6_miso", {31'd0, miso}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_ready", {31'd0, data_ready}, 32'd1);
    cs_n = 1'b1;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (SS + 3) @(negedge clk);
    check("t6_no_pulses", (done_cnt - d0) + (abort_cnt - a0), 32'd0);
    load(8'h5A);
    d0 = done_cnt;
    transfer(8, rd, bm, be);
    check("t6_rd", {24'd0, rd}, 32'h5A);
    check("t6_done", done_cnt - d0, 32'd1);
    check("t6_underrun", {31'd0, underrun}, 32'd0);

    // randomized transfers against the reference model
    do_reset();
    model_reset();
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(2, 0) != 0) begin
        w = 8'($urandom);
        load(w);
        model_load(w);
        if ($urandom_range(3, 0) == 0) begin
          w = 8'($urandom);
          load(w);
          model_load(w);
        end
      end
      check($sformatf("rnd%0d_ready_pre", it), {31'd0, data_ready}, {31'd0, ~m_full});
      n = ($urandom_range(1, 0) == 1) ? 8 : $urandom_range(7, 1);
      d0 = done_cnt;
      a0 = abort_cnt;
      model_xfer(n, exp);
      transfer(n, rd, bm, be);
      check($sformatf("rnd%0d_rd", it), {24'd0, rd}, {24'd0, exp});
      check($sformatf("rnd%0d_done", it), done_cnt - d0, (n == 8) ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_abort", it), abort_cnt - a0, (n == 8) ? 32'd0 : 32'd1);
      check($sformatf("rnd%0d_underrun", it), {31'd0, underrun}, {31'd0, m_under});
      check($sformatf("rnd%0d_busy_end", it), {31'd0, be}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
